// File: rtl/serial_frame_ctrl_pkg.sv
// Shared constants, state encoding and word packing rule for the serial-line frame path.
package serial_frame_ctrl_pkg;

  localparam int unsigned NWORDS  = 27;
  localparam int unsigned WORD_W  = 35;
  localparam int unsigned HS_W    = 16;
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned NUMS_W  = NWORDS * WORD_W;
  localparam int unsigned FRAME_W = 2 * HS_W + NUMS_W;

  localparam logic [HS_W-1:0] HS_I_EXP = 16'hA5A5;
  localparam logic [HS_W-1:0] HS_F_EXP = 16'h5A5A;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StCheck,
    StWrite,
    StDone
  } state_e;

  // Word k lives at bits [WORD_W*k + WORD_W-1 : WORD_W*k] of the packed vector.
  function automatic logic [WORD_W-1:0] get_word(input logic [NUMS_W-1:0] nums,
                                                 input int unsigned       k);
    return nums[k*WORD_W +: WORD_W];
  endfunction

  function automatic logic [NUMS_W-1:0] put_word(input logic [NUMS_W-1:0] nums,
                                                 input int unsigned       k,
                                                 input logic [WORD_W-1:0] word);
    logic [NUMS_W-1:0] res;
    res = nums;
    res[k*WORD_W +: WORD_W] = word;
    return res;
  endfunction

endpackage

// File: rtl/serial_frame_ctrl_word_mux.sv
// Combinational selection of one data word from the packed frame; out-of-range index yields 0.
module frame_word_mux
  import serial_frame_ctrl_pkg::*;
(
  input  logic [NUMS_W-1:0] nums_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [WORD_W-1:0] word_o
);

  always_comb begin
    word_o = '0;
    if (idx_i < IDX_W'(NWORDS)) begin
      word_o = get_word(nums_i, 32'(idx_i));
    end
  end

endmodule

// File: rtl/serial_frame_ctrl.sv
// Detects a newly delivered receiver frame, lets it settle, validates the handshakes and
// commits the 27 words to the parameter file over a valid/ready write port.
module serial_frame_ctrl
  import serial_frame_ctrl_pkg::*;
#(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [HS_W-1:0]   handshake_i,
  input  logic [HS_W-1:0]   handshake_f,
  input  logic [NUMS_W-1:0] nums_flat,
  output logic              wr_valid,
  output logic [IDX_W-1:0]  wr_addr,
  output logic [WORD_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic              frame_ok,
  output logic              frame_err,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       err_cnt
);

  localparam logic [7:0]       SettleLast = 8'(STABLE_CYC - 1);
  localparam logic [IDX_W-1:0] LastIdx    = IDX_W'(NWORDS - 1);

  state_e              state_q;
  logic [FRAME_W-1:0]  shadow_q;
  logic [7:0]          settle_q;
  logic [IDX_W-1:0]    idx_q;
  logic                wr_valid_q;
  logic                frame_ok_q;
  logic                frame_err_q;
  logic                busy_q;
  logic [15:0]         frame_cnt_q;
  logic [15:0]         err_cnt_q;

  logic [FRAME_W-1:0]  snapshot;
  logic                change;
  logic                hs_ok;
  logic [WORD_W-1:0]   cur_word;

  assign snapshot = {handshake_i, nums_flat, handshake_f};
  assign change   = (snapshot != shadow_q);
  assign hs_ok    = (shadow_q[FRAME_W-1 -: HS_W] == HS_I_EXP) &&
                    (shadow_q[HS_W-1:0] == HS_F_EXP);

  frame_word_mux u_word_mux (
    .nums_i (shadow_q[HS_W +: NUMS_W]),
    .idx_i  (idx_q),
    .word_o (cur_word)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      shadow_q    <= '0;
      settle_q    <= '0;
      idx_q       <= '0;
      wr_valid_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (change) begin
            shadow_q <= snapshot;
            settle_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= StSettle;
          end
        end
        StSettle: begin
          if (change) begin
            shadow_q <= snapshot;
            settle_q <= '0;
          end else if (settle_q == SettleLast) begin
            state_q <= StCheck;
          end else begin
            settle_q <= settle_q + 8'd1;
          end
        end
        StCheck: begin
          if (hs_ok) begin
            idx_q      <= '0;
            wr_valid_q <= 1'b1;
            state_q    <= StWrite;
          end else begin
            frame_err_q <= 1'b1;
            if (err_cnt_q != 16'hFFFF) begin
              err_cnt_q <= err_cnt_q + 16'd1;
            end
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StWrite: begin
          if (wr_ready) begin
            if (idx_q == LastIdx) begin
              wr_valid_q  <= 1'b0;
              frame_ok_q  <= 1'b1;
              frame_cnt_q <= frame_cnt_q + 16'd1;
              state_q     <= StDone;
            end else begin
              idx_q <= idx_q + 5'd1;
            end
          end
        end
        StDone: begin
          idx_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Address and data are forced to zero outside a write so idle outputs stay quiet.
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_valid_q ? idx_q : '0;
  assign wr_data   = wr_valid_q ? cur_word : '0;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule
